// File: rtl/nv_nvdla_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nv_nvdla_pipe_pkg
// Brief    : Shared limits and width helpers for the NVDLA elastic pipe stages.
// Revision : 1.0 - initial release
// ============================================================================
package nv_nvdla_pipe_pkg;

    localparam int PIPE_MAX_DEPTH = 16;
    localparam int STALL_CNT_W    = 32;

    // Pointer width; a one-entry buffer still needs a 1-bit pointer to be legal.
    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Occupancy width: must hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nv_nvdla_pipe_stall_cnt.sv
`default_nettype none
// ============================================================================
// Module   : nv_nvdla_pipe_stall_cnt
// Brief    : Saturating stall-cycle counter with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module nv_nvdla_pipe_stall_cnt
    import nv_nvdla_pipe_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_inc,
    input  logic                   i_clr,
    output logic [STALL_CNT_W-1:0] o_cnt
);

    logic [STALL_CNT_W-1:0] r_cnt;

    // Clear wins over increment; the counter sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + STALL_CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/nv_nvdla_mcif_read_ig_elastic_pipe.sv
`default_nettype none
// ============================================================================
// Module   : nv_nvdla_mcif_read_ig_elastic_pipe
// Brief    : DEPTH-entry registered valid/ready pipe for the MCIF read ingress
//            path, with occupancy and almost-full reporting.
//            Optional stall counter: define NV_NVDLA_PIPE_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nv_nvdla_mcif_read_ig_elastic_pipe
    import nv_nvdla_pipe_pkg::*;
#(
    parameter int WIDTH        = 79,
    parameter int DEPTH        = 2,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                      nvdla_core_clk,
    input  logic                      nvdla_core_rst,
`ifdef NV_NVDLA_PIPE_STALL_CNT_EN
    input  logic                      stall_clr,
    output logic [STALL_CNT_W-1:0]    stall_cnt,
`endif
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  logic [WIDTH-1:0]          in_pd,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [WIDTH-1:0]          out_pd,
    output logic [cnt_w(DEPTH)-1:0]   occ,
    output logic                      afull
);

    localparam int                    c_PW        = ptr_w(DEPTH);
    localparam int                    c_CW        = cnt_w(DEPTH);
    localparam logic [c_PW-1:0]       c_PTR_LAST  = c_PW'(DEPTH - 1);
    localparam logic [c_CW-1:0]       c_CNT_FULL  = c_CW'(DEPTH);
    localparam logic [c_CW-1:0]       c_CNT_AFULL = c_CW'(AFULL_THRESH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_cnt;
    logic             r_rdy;

    logic             w_push;
    logic             w_pop;
    logic [c_CW-1:0]  w_cnt_nxt;

    // Explicit wrap so non-power-of-two depths never index past the array.
    function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + c_PW'(1);
    endfunction

    assign w_push    = in_vld & r_rdy & ~nvdla_core_rst;
    assign w_pop     = (r_cnt != '0) & out_rdy & ~nvdla_core_rst;
    assign w_cnt_nxt = r_cnt + c_CW'(w_push) - c_CW'(w_pop);

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_rdy    <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_cnt <= w_cnt_nxt;
            // Ready looks at next occupancy so it is a pure flop output.
            r_rdy <= (w_cnt_nxt < c_CNT_FULL);
        end
    end

    // Payload storage is intentionally not reset.
    always_ff @(posedge nvdla_core_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_pd;
        end
    end

    assign in_rdy  = r_rdy;
    assign out_vld = (r_cnt != '0);
    assign out_pd  = r_mem[r_rd_ptr];
    assign occ     = r_cnt;
    assign afull   = (r_cnt >= c_CNT_AFULL);

`ifdef NV_NVDLA_PIPE_STALL_CNT_EN
    nv_nvdla_pipe_stall_cnt u_stall_cnt (
        .clk   (nvdla_core_clk),
        .rst   (nvdla_core_rst),
        .i_inc (out_vld & ~out_rdy),
        .i_clr (stall_clr),
        .o_cnt (stall_cnt)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_nv_nvdla_mcif_read_ig_elastic_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_nv_nvdla_mcif_read_ig_elastic_pipe
// Brief    : Scoreboard bench over DEPTH=2/4/3 instances of the elastic pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nv_nvdla_mcif_read_ig_elastic_pipe;

    localparam int W = 16;

    logic             clk;
    logic             rst;
    logic [2:0]       in_vld;
    logic [2:0]       out_rdy;
    logic [W-1:0]     in_pd [3];
    logic [2:0]       in_rdy_w;
    logic [2:0]       out_vld_w;
    logic [2:0]       afull_w;
    logic [W-1:0]     pd0, pd1, pd2;
    logic [1:0]       occ0;
    logic [2:0]       occ1;
    logic [1:0]       occ2;
`ifdef NV_NVDLA_PIPE_STALL_CNT_EN
    logic             stall_clr;
    logic [31:0]      stall_cnt0, stall_cnt1, stall_cnt2;
`endif

    int               n_chk;
    int               n_pass;
    int               mcnt [3];
    bit               mrdy [3];
    logic [W-1:0]     q0 [$];
    logic [W-1:0]     q1 [$];
    logic [W-1:0]     q2 [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    nv_nvdla_mcif_read_ig_elastic_pipe #(.WIDTH(W), .DEPTH(2)) u_p2 (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
`ifdef NV_NVDLA_PIPE_STALL_CNT_EN
        .stall_clr      (stall_clr),
        .stall_cnt      (stall_cnt0),
`endif
        .in_vld         (in_vld[0]),
        .in_rdy         (in_rdy_w[0]),
        .in_pd          (in_pd[0]),
        .out_vld        (out_vld_w[0]),
        .out_rdy        (out_rdy[0]),
        .out_pd         (pd0),
        .occ            (occ0),
        .afull          (afull_w[0])
    );

    nv_nvdla_mcif_read_ig_elastic_pipe #(.WIDTH(W), .DEPTH(4)) u_p4 (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
`ifdef NV_NVDLA_PIPE_STALL_CNT_EN
        .stall_clr      (stall_clr),
        .stall_cnt      (stall_cnt1),
`endif
        .in_vld         (in_vld[1]),
        .in_rdy         (in_rdy_w[1]),
        .in_pd          (in_pd[1]),
        .out_vld        (out_vld_w[1]),
        .out_rdy        (out_rdy[1]),
        .out_pd         (pd1),
        .occ            (occ1),
        .afull          (afull_w[1])
    );

    nv_nvdla_mcif_read_ig_elastic_pipe #(.WIDTH(W), .DEPTH(3)) u_p3 (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
`ifdef NV_NVDLA_PIPE_STALL_CNT_EN
        .stall_clr      (stall_clr),
        .stall_cnt      (stall_cnt2),
`endif
        .in_vld         (in_vld[2]),
        .in_rdy         (in_rdy_w[2]),
        .in_pd          (in_pd[2]),
        .out_vld        (out_vld_w[2]),
        .out_rdy        (out_rdy[2]),
        .out_pd         (pd2),
        .occ            (occ2),
        .afull          (afull_w[2])
    );

    function automatic int dep(input int k);
        case (k)
            0:       return 2;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic logic [3:0] get_occ(input int k);
        case (k)
            0:       return {2'b00, occ0};
            1:       return {1'b0, occ1};
            default: return {2'b00, occ2};
        endcase
    endfunction

    function automatic logic [W-1:0] get_pd(input int k);
        case (k)
            0:       return pd0;
            1:       return pd1;
            default: return pd2;
        endcase
    endfunction

    function automatic logic [W-1:0] q_head(input int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    // One clock of all three pipes: check outputs against the model, then advance.
    task automatic tick();
        bit push [3];
        bit pop  [3];
        bit r;
        r = rst;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (in_rdy_w[k] !== mrdy[k])
                $display("FAIL in_rdy[%0d]: got %b want %b", k, in_rdy_w[k], mrdy[k]);
            else n_pass++;
            n_chk++;
            if (out_vld_w[k] !== (mcnt[k] != 0))
                $display("FAIL out_vld[%0d]: got %b want %b", k, out_vld_w[k], (mcnt[k] != 0));
            else n_pass++;
            n_chk++;
            if (get_occ(k) !== 4'(mcnt[k]))
                $display("FAIL occ[%0d]: got %0d want %0d", k, get_occ(k), mcnt[k]);
            else n_pass++;
            n_chk++;
            if (afull_w[k] !== (mcnt[k] >= dep(k) - 1))
                $display("FAIL afull[%0d]: got %b want %b", k, afull_w[k], (mcnt[k] >= dep(k) - 1));
            else n_pass++;
            if (mcnt[k] != 0) begin
                n_chk++;
                if (get_pd(k) !== q_head(k))
                    $display("FAIL out_pd[%0d]: got %h want %h", k, get_pd(k), q_head(k));
                else n_pass++;
            end
            push[k] = in_vld[k] && mrdy[k] && !r;
            pop[k]  = (mcnt[k] != 0) && out_rdy[k] && !r;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                mcnt[k] = 0;
                mrdy[k] = 1'b1;
                case (k)
                    0:       q0.delete();
                    1:       q1.delete();
                    default: q2.delete();
                endcase
            end else begin
                case (k)
                    0: begin
                        if (pop[k])  void'(q0.pop_front());
                        if (push[k]) q0.push_back(in_pd[k]);
                    end
                    1: begin
                        if (pop[k])  void'(q1.pop_front());
                        if (push[k]) q1.push_back(in_pd[k]);
                    end
                    default: begin
                        if (pop[k])  void'(q2.pop_front());
                        if (push[k]) q2.push_back(in_pd[k]);
                    end
                endcase
                mcnt[k] = mcnt[k] + int'(push[k]) - int'(pop[k]);
                mrdy[k] = (mcnt[k] < dep(k));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_chk++;
        if (in_rdy_w !== 3'b111) $display("FAIL reset_in_rdy: got %b want 111", in_rdy_w);
        else n_pass++;
        n_chk++;
        if (out_vld_w !== 3'b000) $display("FAIL reset_out_vld: got %b want 000", out_vld_w);
        else n_pass++;
        n_chk++;
        if (occ1 !== 3'd0 || afull_w[1] !== 1'b0)
            $display("FAIL reset_occ: got occ %0d afull %b want 0 0", occ1, afull_w[1]);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_pass_through();
        out_rdy[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_vld[0] = 1'b1;
            in_pd[0]  = W'(i);
            tick();
            n_chk++;
            if (out_vld_w[0] !== 1'b1 || pd0 !== W'(i) || in_rdy_w[0] !== 1'b1)
                $display("FAIL pass_through: got vld %b pd %h rdy %b want 1 %h 1",
                         out_vld_w[0], pd0, in_rdy_w[0], W'(i));
            else n_pass++;
        end
        in_vld[0] = 1'b0;
        repeat (3) tick();
        out_rdy[0] = 1'b0;
    endtask

    task automatic test_fill_drain();
        out_rdy[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_vld[1] = 1'b1;
            in_pd[1]  = W'(16'h0010 + i);
            tick();
        end
        in_vld[1] = 1'b0;
        n_chk++;
        if (occ1 !== 3'd4 || in_rdy_w[1] !== 1'b0 || afull_w[1] !== 1'b1)
            $display("FAIL fill: got occ %0d rdy %b afull %b want 4 0 1", occ1, in_rdy_w[1], afull_w[1]);
        else n_pass++;
        out_rdy[1] = 1'b1;
        tick();
        n_chk++;
        if (in_rdy_w[1] !== 1'b1 || occ1 !== 3'd3)
            $display("FAIL full_recover: got rdy %b occ %0d want 1 3", in_rdy_w[1], occ1);
        else n_pass++;
        repeat (4) tick();
        out_rdy[1] = 1'b0;
    endtask

    task automatic test_push_pop_cnt1();
        in_vld[1]  = 1'b1;
        in_pd[1]   = 16'h000A;
        out_rdy[1] = 1'b0;
        tick();
        in_pd[1]   = 16'h000B;
        out_rdy[1] = 1'b1;
        tick();
        n_chk++;
        if (pd1 !== 16'h000B || occ1 !== 3'd1)
            $display("FAIL push_pop_cnt1: got pd %h occ %0d want 000b 1", pd1, occ1);
        else n_pass++;
        in_vld[1] = 1'b0;
        repeat (2) tick();
        out_rdy[1] = 1'b0;
    endtask

    task automatic test_mid_reset();
        out_rdy[1] = 1'b0;
        in_vld[1]  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pd[1] = W'(16'h0C00 + i);
            tick();
        end
        n_chk++;
        if (occ1 !== 3'd3) $display("FAIL mid_reset_pre: got occ %0d want 3", occ1);
        else n_pass++;
        rst      = 1'b1;
        in_pd[1] = 16'h0055;
        tick();
        rst       = 1'b0;
        in_vld[1] = 1'b0;
        n_chk++;
        if (occ1 !== 3'd0 || out_vld_w[1] !== 1'b0 || in_rdy_w[1] !== 1'b1)
            $display("FAIL mid_reset: got occ %0d vld %b rdy %b want 0 0 1", occ1, out_vld_w[1], in_rdy_w[1]);
        else n_pass++;
        repeat (2) tick();
    endtask

    task automatic test_wrap_random();
        for (int i = 0; i < 1000; i++) begin
            in_vld[2]  = 1'($urandom_range(0, 1));
            out_rdy[2] = 1'($urandom_range(0, 1));
            in_pd[2]   = W'($urandom);
            tick();
        end
        in_vld[2]  = 1'b0;
        out_rdy[2] = 1'b1;
        repeat (4) tick();
        n_chk++;
        if (occ2 !== 2'd0 || q2.size() != 0)
            $display("FAIL wrap_drain: got occ %0d model %0d want 0", occ2, q2.size());
        else n_pass++;
        out_rdy[2] = 1'b0;
    endtask

`ifdef NV_NVDLA_PIPE_STALL_CNT_EN
    task automatic test_stall_cnt();
        out_rdy[1] = 1'b0;
        in_vld[1]  = 1'b1;
        in_pd[1]   = 16'h0077;
        stall_clr  = 1'b1;
        tick();
        in_vld[1]  = 1'b0;
        stall_clr  = 1'b0;
        repeat (5) tick();
        n_chk++;
        if (stall_cnt1 !== 32'd5) $display("FAIL stall_cnt: got %0d want 5", stall_cnt1);
        else n_pass++;
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        n_chk++;
        if (stall_cnt1 !== 32'd0) $display("FAIL stall_clr: got %0d want 0", stall_cnt1);
        else n_pass++;
        out_rdy[1] = 1'b1;
        repeat (2) tick();
        out_rdy[1] = 1'b0;
    endtask
`endif

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        rst     = 1'b1;
        in_vld  = 3'b000;
        out_rdy = 3'b000;
        for (int k = 0; k < 3; k++) begin
            in_pd[k] = '0;
            mcnt[k]  = 0;
            mrdy[k]  = 1'b1;
        end
`ifdef NV_NVDLA_PIPE_STALL_CNT_EN
        stall_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_pass_through();
        test_fill_drain();
        test_push_pop_cnt1();
        test_mid_reset();
        test_wrap_random();
`ifdef NV_NVDLA_PIPE_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
